// File: rtl/fetch_responder.sv
// Fetch responder: turns the PC unit's current PC into single-outstanding
// instruction-memory requests and holds the returned word in a one-entry buffer for stage2.
module fetch_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_Out,
  input  logic        PC_Sel,
  input  logic        stage2_ready,
  output logic        icache_req_valid,
  input  logic        icache_req_ready,
  output logic [31:0] icache_req_addr,
  input  logic        icache_resp_valid,
  input  logic [31:0] icache_resp_data,
  output logic [31:0] Inst_Out,
  output logic [31:0] Inst_PC,
  output logic        Inst_Valid,
  output logic        stall
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_KILL = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_req_pc;
  logic [31:0] r_inst_out;
  logic [31:0] r_inst_pc;
  logic        r_inst_valid;

  logic w_drain;
  logic w_issue;
  logic w_fire;
  logic w_load;

  // A redirect cycle never counts as a drain: stage2 ignores its own transfer then.
  assign w_drain = r_inst_valid & stage2_ready & ~PC_Sel;
  assign w_issue = reset & (r_state == ST_REQ) & (~r_inst_valid | w_drain);
  assign w_fire  = w_issue & icache_req_ready;
  assign w_load  = (r_state == ST_WAIT) & icache_resp_valid & ~PC_Sel;

  assign icache_req_valid = w_issue;
  assign icache_req_addr  = PC_Out;
  // The PC only moves on an accepted fetch or a redirect; held throughout reset.
  assign stall            = ~reset | (~w_fire & ~PC_Sel);

  assign Inst_Out   = r_inst_out;
  assign Inst_PC    = r_inst_pc;
  assign Inst_Valid = r_inst_valid;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_REQ;
      r_req_pc     <= '0;
      r_inst_out   <= '0;
      r_inst_pc    <= '0;
      r_inst_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_fire) begin
            r_req_pc <= PC_Out;
            r_state  <= PC_Sel ? ST_KILL : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (icache_resp_valid) begin
            if (!PC_Sel) begin
              r_inst_out <= icache_resp_data;
              r_inst_pc  <= r_req_pc;
            end
            r_state <= ST_REQ;
          end else if (PC_Sel) begin
            r_state <= ST_KILL;
          end
        end
        ST_KILL: begin
          // Wrong-path response still owed by memory; swallow it.
          if (icache_resp_valid) r_state <= ST_REQ;
        end
        default: r_state <= ST_REQ;
      endcase

      if (PC_Sel)       r_inst_valid <= 1'b0;
      else if (w_load)  r_inst_valid <= 1'b1;
      else if (w_drain) r_inst_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_responder.sv
// Bench for fetch_responder: directed scenarios plus randomized traffic, all
// checked against a transaction-level model of the buffer and outstanding request.
module tb_fetch_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] PC_Out = '0;
  logic        PC_Sel = 1'b0;
  logic        stage2_ready = 1'b0;
  logic        icache_req_valid;
  logic        icache_req_ready = 1'b0;
  logic [31:0] icache_req_addr;
  logic        icache_resp_valid = 1'b0;
  logic [31:0] icache_resp_data = '0;
  logic [31:0] Inst_Out;
  logic [31:0] Inst_PC;
  logic        Inst_Valid;
  logic        stall;
  logic [31:0] alu_out = '0;

  fetch_responder dut (
    .clk              (clk),
    .reset            (reset),
    .PC_Out           (PC_Out),
    .PC_Sel           (PC_Sel),
    .stage2_ready     (stage2_ready),
    .icache_req_valid (icache_req_valid),
    .icache_req_ready (icache_req_ready),
    .icache_req_addr  (icache_req_addr),
    .icache_resp_valid(icache_resp_valid),
    .icache_resp_data (icache_resp_data),
    .Inst_Out         (Inst_Out),
    .Inst_PC          (Inst_PC),
    .Inst_Valid       (Inst_Valid),
    .stall            (stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: one buffer slot plus at most one outstanding request.
  bit          m_buf;
  logic [31:0] m_buf_pc;
  logic [31:0] m_buf_data;
  bit          m_out;
  bit          m_killed;
  logic [31:0] m_out_addr;
  int          m_cnt;
  int          mem_lat = 1;
  bit          ovr_en;
  logic [31:0] ovr_addr;
  logic [31:0] ovr_data;

  // Values sampled in the most recent cycle.
  bit          s_fire, s_valid, s_req_valid, s_stall;
  logic [31:0] s_addr, s_inst, s_ipc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr_en && a == ovr_addr) return ovr_data;
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  // Called at posedge+1 with this cycle's inputs applied; samples, checks,
  // advances the model, then applies PC and memory response for the next cycle.
  task automatic cycle();
    bit          drain, exp_req, fire, load, exp_stall;
    logic [31:0] nxt_pc;
    #3;
    s_req_valid = icache_req_valid;
    s_fire      = icache_req_valid & icache_req_ready;
    s_stall     = stall;
    s_addr      = icache_req_addr;
    s_valid     = Inst_Valid;
    s_inst      = Inst_Out;
    s_ipc       = Inst_PC;

    drain     = m_buf && stage2_ready && !PC_Sel;
    exp_req   = !m_out && (!m_buf || drain);
    fire      = exp_req && icache_req_ready;
    exp_stall = !fire && !PC_Sel;

    n_checks++;
    if (s_req_valid !== exp_req)
      $display("FAIL model_req_valid cyc=%0d got=%b exp=%b", cyc, s_req_valid, exp_req);
    else n_pass++;
    n_checks++;
    if (s_addr !== PC_Out)
      $display("FAIL model_req_addr cyc=%0d got=%h exp=%h", cyc, s_addr, PC_Out);
    else n_pass++;
    n_checks++;
    if (s_stall !== exp_stall)
      $display("FAIL model_stall cyc=%0d got=%b exp=%b", cyc, s_stall, exp_stall);
    else n_pass++;
    n_checks++;
    if (s_valid !== m_buf)
      $display("FAIL model_inst_valid cyc=%0d got=%b exp=%b", cyc, s_valid, m_buf);
    else n_pass++;
    if (m_buf) begin
      n_checks++;
      if (s_ipc !== m_buf_pc || s_inst !== m_buf_data)
        $display("FAIL model_inst cyc=%0d got pc=%h data=%h exp pc=%h data=%h",
                 cyc, s_ipc, s_inst, m_buf_pc, m_buf_data);
      else n_pass++;
    end

    load = 1'b0;
    if (icache_resp_valid && m_out) begin
      if (!m_killed && !PC_Sel) begin
        load       = 1'b1;
        m_buf_pc   = m_out_addr;
        m_buf_data = mem_word(m_out_addr);
      end
      m_out = 1'b0;
    end
    if (PC_Sel)     m_buf = 1'b0;
    else if (load)  m_buf = 1'b1;
    else if (drain) m_buf = 1'b0;
    if (PC_Sel && m_out) m_killed = 1'b1;
    if (fire) begin
      m_out      = 1'b1;
      m_out_addr = PC_Out;
      m_killed   = PC_Sel;
      m_cnt      = mem_lat;
    end

    nxt_pc = PC_Sel ? alu_out : (stall ? PC_Out : PC_Out + 32'd4);
    @(posedge clk);
    #1;
    PC_Out            = nxt_pc;
    icache_resp_valid = 1'b0;
    icache_resp_data  = $urandom;
    if (m_out) begin
      m_cnt--;
      if (m_cnt <= 0) begin
        icache_resp_valid = 1'b1;
        icache_resp_data  = mem_word(m_out_addr);
      end
    end
    cyc++;
  endtask

  task automatic hold_reset(input logic [31:0] start_pc);
    @(posedge clk);
    #1;
    reset             = 1'b0;
    PC_Sel            = 1'b0;
    stage2_ready      = 1'b1;
    icache_req_ready  = 1'b1;
    icache_resp_valid = 1'b0;
    alu_out           = '0;
    PC_Out            = start_pc;
    m_buf = 1'b0; m_out = 1'b0; m_killed = 1'b0; m_cnt = 0;
    ovr_en = 1'b0; mem_lat = 1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    reset = 1'b1;
    cyc   = 1;
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    hold_reset(start_pc);
    release_reset();
  endtask

  task automatic test_reset();
    hold_reset(32'h0);
    PC_Sel = 1'b1;
    #3;
    n_checks++;
    if (icache_req_valid !== 1'b0 || stall !== 1'b1)
      $display("FAIL reset_handshake got req_valid=%b stall=%b exp 0/1", icache_req_valid, stall);
    else n_pass++;
    n_checks++;
    if (Inst_Valid !== 1'b0 || Inst_Out !== 32'h0 || Inst_PC !== 32'h0)
      $display("FAIL reset_buffer got v=%b out=%h pc=%h exp 0/0/0", Inst_Valid, Inst_Out, Inst_PC);
    else n_pass++;
    PC_Sel = 1'b0;
  endtask

  task automatic test_basic();
    int c;
    bit exp_fire, exp_valid;
    do_reset(32'h0);
    for (int i = 1; i <= 7; i++) begin
      c = cyc;
      cycle();
      exp_fire  = (c % 2 == 1);
      exp_valid = (c >= 3) && (c % 2 == 1);
      n_checks++;
      if (s_fire !== exp_fire || s_stall !== !exp_fire)
        $display("FAIL basic_fire cyc=%0d got fire=%b stall=%b exp fire=%b", c, s_fire, s_stall, exp_fire);
      else n_pass++;
      n_checks++;
      if (s_valid !== exp_valid)
        $display("FAIL basic_valid cyc=%0d got=%b exp=%b", c, s_valid, exp_valid);
      else n_pass++;
      if (exp_valid) begin
        n_checks++;
        if (s_ipc !== 32'((c - 3) * 2))
          $display("FAIL basic_inst_pc cyc=%0d got=%h exp=%h", c, s_ipc, 32'((c - 3) * 2));
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    int c;
    do_reset(32'h0);
    for (int i = 1; i <= 9; i++) begin
      c = cyc;
      stage2_ready = !(c >= 3 && c <= 6);
      cycle();
      if (c >= 3 && c <= 6) begin
        n_checks++;
        if (s_valid !== 1'b1 || s_ipc !== 32'h0 || s_inst !== mem_word(32'h0))
          $display("FAIL bp_hold cyc=%0d got v=%b pc=%h data=%h", c, s_valid, s_ipc, s_inst);
        else n_pass++;
        n_checks++;
        if (s_req_valid !== 1'b0 || s_stall !== 1'b1)
          $display("FAIL bp_no_req cyc=%0d got req_valid=%b stall=%b exp 0/1", c, s_req_valid, s_stall);
        else n_pass++;
      end
      if (c == 7) begin
        n_checks++;
        if (s_fire !== 1'b1 || s_stall !== 1'b0 || s_addr !== 32'h4)
          $display("FAIL bp_resume got fire=%b stall=%b addr=%h exp 1/0/4", s_fire, s_stall, s_addr);
        else n_pass++;
      end
      if (c == 9) begin
        n_checks++;
        if (s_valid !== 1'b1 || s_ipc !== 32'h4)
          $display("FAIL bp_second got v=%b pc=%h exp 1/4", s_valid, s_ipc);
        else n_pass++;
      end
    end
  endtask

  task automatic test_redirect_wait();
    int c;
    do_reset(32'h10);
    mem_lat  = 4;
    ovr_en   = 1'b1;
    ovr_addr = 32'h10;
    ovr_data = 32'hDEAD_BEEF;
    alu_out  = 32'h200;
    for (int i = 1; i <= 8; i++) begin
      c = cyc;
      PC_Sel = (c == 2);
      cycle();
      n_checks++;
      if (s_valid === 1'b1 && s_inst === 32'hDEAD_BEEF)
        $display("FAIL rw_leak cyc=%0d got killed data %h delivered", c, s_inst);
      else n_pass++;
      if (c == 1) begin
        n_checks++;
        if (s_fire !== 1'b1 || s_addr !== 32'h10)
          $display("FAIL rw_first got fire=%b addr=%h exp 1/10", s_fire, s_addr);
        else n_pass++;
      end
      if (c >= 2 && c <= 5) begin
        n_checks++;
        if (s_req_valid !== 1'b0)
          $display("FAIL rw_kill_wait cyc=%0d got req_valid=%b exp 0", c, s_req_valid);
        else n_pass++;
      end
      if (c == 6) begin
        n_checks++;
        if (s_fire !== 1'b1 || s_addr !== 32'h200)
          $display("FAIL rw_new_target got fire=%b addr=%h exp 1/200", s_fire, s_addr);
        else n_pass++;
      end
    end
    PC_Sel = 1'b0;
  endtask

  task automatic test_redirect_fire();
    int c;
    do_reset(32'h0);
    for (int i = 1; i <= 7; i++) begin
      c = cyc;
      PC_Sel  = (c == 3) || (c == 4);
      alu_out = (c == 3) ? 32'h300 : 32'h400;
      if (c == 4) mem_lat = 2;
      cycle();
      if (c == 3) begin
        n_checks++;
        if (s_valid !== 1'b1 || s_req_valid !== 1'b0 || s_stall !== 1'b0)
          $display("FAIL rf_redirect_buf got v=%b req=%b stall=%b exp 1/0/0", s_valid, s_req_valid, s_stall);
        else n_pass++;
      end
      if (c == 4) begin
        n_checks++;
        if (s_valid !== 1'b0 || s_fire !== 1'b1 || s_addr !== 32'h300 || s_stall !== 1'b0)
          $display("FAIL rf_fire_with_redirect got v=%b fire=%b addr=%h stall=%b", s_valid, s_fire, s_addr, s_stall);
        else n_pass++;
      end
      if (c == 5 || c == 6) begin
        n_checks++;
        if (s_req_valid !== 1'b0 || s_valid !== 1'b0)
          $display("FAIL rf_kill cyc=%0d got req=%b v=%b exp 0/0", c, s_req_valid, s_valid);
        else n_pass++;
      end
      if (c == 7) begin
        n_checks++;
        if (s_valid !== 1'b0 || s_fire !== 1'b1 || s_addr !== 32'h400)
          $display("FAIL rf_after_kill got v=%b fire=%b addr=%h exp 0/1/400", s_valid, s_fire, s_addr);
        else n_pass++;
      end
    end
    PC_Sel = 1'b0;
  endtask

  task automatic test_slow_mem();
    int c;
    int fires;
    do_reset(32'h40);
    mem_lat      = 5;
    stage2_ready = 1'b0;
    fires        = 0;
    for (int i = 1; i <= 10; i++) begin
      c = cyc;
      icache_req_ready = (c >= 4);
      cycle();
      if (s_fire) fires++;
      if (c <= 3) begin
        n_checks++;
        if (s_req_valid !== 1'b1 || s_stall !== 1'b1 || s_addr !== 32'h40)
          $display("FAIL slow_wait cyc=%0d got req=%b stall=%b addr=%h", c, s_req_valid, s_stall, s_addr);
        else n_pass++;
      end
      if (c == 10) begin
        n_checks++;
        if (s_valid !== 1'b1 || s_ipc !== 32'h40 || s_inst !== mem_word(32'h40))
          $display("FAIL slow_deliver got v=%b pc=%h data=%h", s_valid, s_ipc, s_inst);
        else n_pass++;
      end
    end
    n_checks++;
    if (fires != 1)
      $display("FAIL slow_fire_count got=%0d exp=1", fires);
    else n_pass++;
    stage2_ready = 1'b1;
  endtask

  task automatic test_reset_wait();
    int c;
    do_reset(32'h80);
    for (int i = 1; i <= 4; i++) begin
      c = cyc;
      if (c == 3) mem_lat = 10;
      cycle();
      if (c == 3) begin
        n_checks++;
        if (s_fire !== 1'b1 || s_addr !== 32'h84)
          $display("FAIL rst_setup_fire got fire=%b addr=%h exp 1/84", s_fire, s_addr);
        else n_pass++;
      end
      if (c == 4) begin
        n_checks++;
        if (s_inst !== mem_word(32'h80) || s_ipc !== 32'h80)
          $display("FAIL rst_setup_buf got data=%h pc=%h", s_inst, s_ipc);
        else n_pass++;
      end
    end
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (icache_req_valid !== 1'b0 || stall !== 1'b1 || Inst_Valid !== 1'b0 ||
        Inst_Out !== 32'h0 || Inst_PC !== 32'h0)
      $display("FAIL rst_immediate got req=%b stall=%b v=%b out=%h pc=%h",
               icache_req_valid, stall, Inst_Valid, Inst_Out, Inst_PC);
    else n_pass++;
    @(posedge clk);
    #1;
    icache_resp_valid = 1'b1;
    icache_resp_data  = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    icache_resp_valid = 1'b0;
    m_buf = 1'b0; m_out = 1'b0; m_killed = 1'b0; mem_lat = 1;
    PC_Out = 32'h100;
    release_reset();
    for (int i = 1; i <= 3; i++) begin
      c = cyc;
      cycle();
      if (c == 1) begin
        n_checks++;
        if (s_valid !== 1'b0 || s_fire !== 1'b1 || s_addr !== 32'h100)
          $display("FAIL rst_release got v=%b fire=%b addr=%h exp 0/1/100", s_valid, s_fire, s_addr);
        else n_pass++;
      end
      if (c == 3) begin
        n_checks++;
        if (s_valid !== 1'b1 || s_ipc !== 32'h100 || s_inst !== mem_word(32'h100))
          $display("FAIL rst_after_deliver got v=%b pc=%h data=%h", s_valid, s_ipc, s_inst);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    int transfers;
    do_reset(32'h0);
    transfers = 0;
    for (int i = 0; i < 2000; i++) begin
      stage2_ready     = ($urandom_range(0, 3) != 0);
      icache_req_ready = ($urandom_range(0, 2) != 0);
      PC_Sel           = ($urandom_range(0, 15) == 0);
      alu_out          = $urandom & 32'hFFFF_FFFC;
      mem_lat          = $urandom_range(1, 4);
      if (Inst_Valid && stage2_ready && !PC_Sel) transfers++;
      cycle();
    end
    PC_Sel = 1'b0;
    n_checks++;
    if (transfers < 50)
      $display("FAIL random_progress got=%0d transfers exp>=50", transfers);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_fire();
    test_slow_mem();
    test_reset_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
